// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-file read side: FSM state encoding,
// dump/single mode values and default geometry of the 8x32 register file.
package reg_dump_reader_pkg;

    localparam int NREG_DEF = 8;
    localparam int AW_DEF   = 3;
    localparam int DW_DEF   = 32;

    localparam logic MODE_DUMP   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SEND_A = 3'd2,
        ST_SEND_B = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Read-side initiator for the register file: walks the two read ports a pair
// of registers at a time (or reads one register), captures both words in the
// same cycle and streams them out over valid/ready with an XOR checksum.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic          clk,
    input  logic          cr,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] sel_addr,
    output logic [AW-1:0] Addr_A,
    output logic [AW-1:0] Addr_B,
    input  logic [DW-1:0] QA,
    input  logic [DW-1:0] QB,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_idx,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum
);

    localparam logic [AW-1:0] LAST_PAIR = AW'(NREG / 2 - 1);

    state_t        state;
    logic          mode_q;
    logic [AW-1:0] pair;
    logic [DW-1:0] buf_a;
    logic [DW-1:0] buf_b;

    // Single FSM with all outputs registered; a word leaves only on handshake.
    always_ff @(posedge clk) begin
        if (cr) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_DUMP;
            pair      <= '0;
            buf_a     <= '0;
            buf_b     <= '0;
            Addr_A    <= '0;
            Addr_B    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        checksum <= '0;
                        busy     <= 1'b1;
                        pair     <= '0;
                        if (mode == MODE_DUMP) begin
                            Addr_A <= '0;
                            Addr_B <= AW'(1);
                        end else begin
                            Addr_A <= sel_addr;
                        end
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    buf_a     <= QA;
                    buf_b     <= QB;
                    out_valid <= 1'b1;
                    out_data  <= QA;
                    out_idx   <= Addr_A;
                    state     <= ST_SEND_A;
                end
                ST_SEND_A: begin
                    if (out_ready) begin
                        checksum <= checksum ^ buf_a;
                        if (mode_q == MODE_SINGLE) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            out_data <= buf_b;
                            out_idx  <= Addr_B;
                            state    <= ST_SEND_B;
                        end
                    end
                end
                ST_SEND_B: begin
                    if (out_ready) begin
                        checksum  <= checksum ^ buf_b;
                        out_valid <= 1'b0;
                        if (pair == LAST_PAIR) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            pair   <= pair + AW'(1);
                            Addr_A <= Addr_A + AW'(2);
                            Addr_B <= Addr_B + AW'(2);
                            state  <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Read-side initiator for the 8x32 register file.
- Drives the file's two read-address ports and captures QA/QB.
- Streams register contents one word at a time over a valid/ready interface to a display/debug consumer.
- Supports a full dump of R0..R7 (two registers fetched per cycle) or a single-register read, and reports an XOR checksum of all words sent.

Parameters:
- NREG, 8, number of registers walked in dump mode; must be even, power of two.
- AW, 3, register address width (log2 NREG).
- DW, 32, data word width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- cr  in  1  synchronous active-high reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- mode  in  1  0 = full dump R0..R(NREG-1); 1 = single read of sel_addr. Sampled with start.
- sel_addr  in  AW  register to read in single mode; sampled with start.
- Addr_A  out  AW  read address to register file port A (registered).
- Addr_B  out  AW  read address to register file port B (registered).
- QA  in  DW  register file port A data (combinational from Addr_A).
- QB  in  DW  register file port B data (combinational from Addr_B).
- out_valid  out  1  out_data/out_idx valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_data  out  DW  register contents.
- out_idx  out  AW  register index of out_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final word is accepted.
- checksum  out  DW  XOR of all words accepted in the current/last operation.

Behaviour:
- Reset (cr=1 at an edge), regardless of state:
  - state=IDLE.
  - Addr_A=0, Addr_B=0.
  - out_valid=0, out_data=0, out_idx=0.
  - busy=0, done=0, checksum=0.
  - Internal pair counter=0; capture buffers=0.
- IDLE:
  - start=1, mode=0 → pair=0, Addr_A=0, Addr_B=1, checksum cleared, go FETCH.
  - start=1, mode=1 → Addr_A=sel_addr, checksum cleared, go FETCH.
  - start=0 → stay.
- FETCH (exactly 1 cycle):
  - Addresses are stable for the whole cycle.
  - At the closing edge: bufA<=QA, bufB<=QB (both in the same cycle, so the pair is coherent); go SEND_A.
  - Writes to the register file in other cycles are not blocked; a dump is coherent per pair only.
- SEND_A:
  - out_valid=1, out_data=bufA, out_idx=Addr_A.
  - Hold out_data/out_idx stable until the handshake.
  - On the handshake: checksum^=bufA.
    - mode=1 → go DONE.
    - mode=0 → go SEND_B.
- SEND_B:
  - out_valid=1, out_data=bufB, out_idx=Addr_B.
  - On the handshake: checksum^=bufB.
    - If pair==NREG/2-1 → go DONE.
    - Otherwise pair++, Addr_A+=2, Addr_B+=2, go FETCH.
- DONE (1 cycle): done=1, out_valid=0, then go IDLE.
- out_valid is 0 in IDLE, FETCH and DONE.
- out_valid never drops without a handshake, except on reset.
- Latency:
  - start → first out_valid = 2 cycles.
  - With out_ready held high, a full dump takes 1 + 4×3 + 1 = 14 cycles from start to done. Single read takes 4.
- start while busy is ignored; mode and sel_addr changes during busy are ignored (latched copies are used).
- Address arithmetic is modulo 2^AW. Addr_B wrap cannot occur because NREG is even.
- The checksum holds its value after done until the next accepted start.

Decomposition:
- Shared package: state encoding constants (IDLE, FETCH, SEND_A, SEND_B, DONE), MODE_DUMP/MODE_SINGLE, and default NREG/AW/DW. The same package will be used by the register-file wrapper.
- No sub-module required. The FSM, pair counter, two capture registers and checksum are all in one module.

Test Plan:
- Reset mid-dump: load R0..R7=32'h1000_0000+i; start mode=0; assert cr during the 2nd SEND_B → next cycle out_valid=0, busy=0, Addr_A=Addr_B=0, checksum=0.
- Full dump, out_ready=1: R0..R7=32'h1000_0000+i; start mode=0 → idx 0..7 with data 32'h1000_0000..32'h1000_0007 in order; done at cycle 14; checksum=32'h0000_0000.
- Backpressure: same data; out_ready toggles 1,0,0,1,… → out_data/out_idx stable while stalled; no word lost or duplicated; sequence identical to the previous test.
- Single read: R5=32'hDEAD_BEEF; start mode=1 sel_addr=5 → one word, idx 5, data 32'hDEAD_BEEF; done 4 cycles after start; checksum=32'hDEAD_BEEF.
- Ignored start: pulse start with mode=1 during a dump → the dump completes all 8 words; no extra transfer; busy falls only after done.
- Pair coherence: write R3=32'hAAAA_5555 in the cycle after the FETCH of pair 1 → the dump shows the old R3 value; a following dump shows 32'hAAAA_5555.
